seg7_scan_ctrl: RTL
===================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 100000, giving clocks per digit slot (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, giving the anti-ghost blank clocks at the start of each slot; legal range 1..DIGIT_CYCLES-2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: 1 = scan display, 0 = display dark.
REQ-006 SHALL have port value, input, 32 bits: eight hex nibbles; nibble k shows on digit k (digit 0 rightmost).
REQ-007 SHALL have port dp_mask, input, 8 bits: bit k lights the decimal point of digit k.
REQ-008 SHALL have port an_n, output, 8 bits: digit anodes, active-low.
REQ-009 SHALL have port seg_n, output, 7 bits: cathodes, active-low; bit0=a through bit6=g.
REQ-010 SHALL have port dp_n, output, 1 bit: decimal-point cathode, active-low.
REQ-011 SHALL have port frame_done, output, 1 bit: one-clock pulse when digit 7's slot ends.

Function
REQ-012 SHALL implement an FSM with states IDLE, BLANK and DRIVE.
REQ-013 IDLE: when enable=1, SHALL load shadow<=value and dp_shadow<=dp_mask, set digit<=0 and prescaler<=0, then go to BLANK.
REQ-014 SHALL count the prescaler 0..DIGIT_CYCLES-1 in BLANK and DRIVE.
REQ-015 SHALL go BLANK->DRIVE when prescaler=BLANK_CYCLES-1.
REQ-016 At prescaler=DIGIT_CYCLES-1 in DRIVE, SHALL zero the prescaler, advance digit (wrapping 7->0) and go to BLANK.
REQ-017 On the 7->0 wrap, SHALL reload shadow and dp_shadow from the inputs and pulse frame_done for that clock; value SHALL be sampled only at frame boundaries (no tearing).
REQ-018 enable=0 in any state SHALL go to IDLE on the next clock, clear the prescaler and digit, and raise no frame_done.
REQ-019 an_n, seg_n and dp_n SHALL be registered and reflect the state and digit one clock after they change.
REQ-020 In IDLE and BLANK, an_n SHALL be 8'hFF, seg_n 7'h7F and dp_n 1.
REQ-021 In DRIVE, an_n SHALL be all ones except bit `digit`=0, seg_n SHALL be the hex decode of shadow[4*digit+3:4*digit], and dp_n SHALL be ~dp_shadow[digit].
REQ-022 Decode table, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7 bits).
REQ-023 Changes to value or dp_mask during a frame SHALL NOT affect the displayed output until the next frame boundary.

Reset
REQ-024 resetn=0 SHALL asynchronously force state=IDLE, prescaler=0, digit=0, shadow=0, dp_shadow=0, an_n=8'hFF, seg_n=7'h7F, dp_n=1 and frame_done=0.
REQ-025 Reset mid-slot SHALL abandon the slot; after release with enable=1, scanning SHALL restart at digit 0 with a fresh load.

Configuration
REQ-026 With SEG7_LZB_EN defined, SHALL apply leading-zero blanking: a digit k>0 whose nibble and every higher nibble of shadow are 0 SHALL keep its anode high and seg_n/dp_n off through its DRIVE slot, unless dp_shadow[k]=1; digit 0 SHALL always be shown.
REQ-027 Without SEG7_LZB_EN, all eight digits SHALL always be driven, and no blanking logic SHALL be synthesised.

Structure
REQ-028 Package seg7_pkg SHALL hold the FSM state encoding, NUM_DIGITS=8, SEG_OFF=7'h7F and the 16-entry decode constant table.
REQ-029 Sub-module seg7_hex_decode SHALL hold the purely combinational nibble-to-seg_n decode and be instantiated once.

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2)
REQ-030 Reset, then enable=1 with value=32'h76543210 -> digits 0..7 show 40,79,24,30,19,12,02,78; anode low 6 of 8 clocks per slot; frame_done every 64 clocks.
REQ-031 Change value from 32'h11111111 to 32'h22222222 while digit 3 is in DRIVE -> digits 4..7 still show 79; next frame shows 24 on all digits.
REQ-032 Drop enable mid-DRIVE of digit 5 -> next output clock an_n=FF; re-enable -> first lit digit is 0 after 2 blank clocks.
REQ-033 Assert resetn=0 asynchronously mid-slot -> outputs reach off values before the next clk edge; no frame_done.
REQ-034 Build with SEG7_LZB_EN, value=32'h000000A0, dp_mask=8'h00 -> only digits 0 (40) and 1 (08) lit; value=0 -> only digit 0 shows 40.
REQ-035 dp_mask=8'h81 with value=32'h0 under SEG7_LZB_EN -> digit 7 lit with seg_n=7F and dp_n=0; digit 0 shows 40 with dp_n=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seven-segment scan controller
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low a..g patterns; element [n] is the glyph for nibble n
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low segment decode
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - eight-digit multiplexed display scanner with per-slot blanking
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int PW = $clog2(DIGIT_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] LAST_PRE   = PW'(DIGIT_CYCLES - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [DW-1:0]   digit;
  logic [31:0]     shadow;
  logic [7:0]      dp_shadow;
  logic [3:0]      nibble;
  logic [6:0]      dec_seg;

  assign nibble = shadow[{digit, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SEG7_LZB_EN
  // Digit is a leading zero when it and everything above it in the shadow is zero
  logic lead_zero;
  assign lead_zero = (digit != '0) && ((shadow >> {digit, 2'b00}) == 32'd0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      prescaler  <= '0;
      digit      <= '0;
      shadow     <= '0;
      dp_shadow  <= '0;
      an_n       <= 8'hFF;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      an_n       <= 8'hFF;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      // Output registers follow the state held during this clock
      if (state == ST_DRIVE) begin
`ifdef SEG7_LZB_EN
        if (!lead_zero || dp_shadow[digit]) an_n <= ~(8'd1 << digit);
        seg_n <= lead_zero ? SEG_OFF : dec_seg;
`else
        an_n  <= ~(8'd1 << digit);
        seg_n <= dec_seg;
`endif
        dp_n  <= ~dp_shadow[digit];
      end

      if (!enable) begin
        state     <= ST_IDLE;
        prescaler <= '0;
        digit     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            shadow    <= value;
            dp_shadow <= dp_mask;
            digit     <= '0;
            prescaler <= '0;
            state     <= ST_BLANK;
          end
          ST_BLANK: begin
            prescaler <= prescaler + 1'b1;
            if (prescaler == BLANK_END) state <= ST_DRIVE;
          end
          ST_DRIVE: begin
            if (prescaler == LAST_PRE) begin
              prescaler <= '0;
              digit     <= digit + 1'b1;
              state     <= ST_BLANK;
              if (digit == LAST_DIGIT) begin
                shadow     <= value;
                dp_shadow  <= dp_mask;
                frame_done <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
